// File: rtl/line_buffer.sv
// Sliding line buffer: turns a raster pixel stream into BLOCK_HEIGHT-tall columns.
// Optional feature: define LINE_BUFFER_SOF_EN to add the in_sof frame-restart input.
module line_buffer #(
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned BLOCK_HEIGHT = 3,
  parameter int unsigned IMAGE_WIDTH  = 640,
  parameter int unsigned IMAGE_HEIGHT = 480
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [DATA_WIDTH-1:0]              in_pixel,
  input  logic                               in_valid,
`ifdef LINE_BUFFER_SOF_EN
  input  logic                               in_sof,
`endif
  output logic                               in_ready,
  output logic [DATA_WIDTH*BLOCK_HEIGHT-1:0] out_pixels,
  output logic [BLOCK_HEIGHT-1:0]            out_valid,
  input  logic [BLOCK_HEIGHT-1:0]            out_ready
);

  localparam int unsigned LINES = BLOCK_HEIGHT - 1;
  localparam int unsigned COL_W = (IMAGE_WIDTH > 1) ? $clog2(IMAGE_WIDTH) : 1;
  localparam int unsigned ROW_W = (IMAGE_HEIGHT > 1) ? $clog2(IMAGE_HEIGHT) : 1;
  localparam int unsigned OUT_W = DATA_WIDTH * BLOCK_HEIGHT;

  typedef enum logic {
    FILL   = 1'b0,
    STREAM = 1'b1
  } state_e;

  state_e                state_q, state_d, state_eff;
  logic [COL_W-1:0]      col_q, col_d, col_eff;
  logic [ROW_W-1:0]      row_q, row_d, row_eff;
  logic [OUT_W-1:0]      pix_q, pix_d;
  logic                  valid_q, valid_d;
  logic [DATA_WIDTH-1:0] line_q [LINES][IMAGE_WIDTH];

  logic accept, consume, load, col_last, row_last;

  assign consume    = valid_q & (&out_ready);
  assign in_ready   = ~valid_q | (&out_ready);
  assign accept     = in_valid & in_ready;
  assign out_pixels = pix_q;
  assign out_valid  = {BLOCK_HEIGHT{valid_q}};

  // Frame position of the pixel being offered; a start-of-frame overrides the counters.
  always_comb begin
    col_eff   = col_q;
    row_eff   = row_q;
    state_eff = state_q;
`ifdef LINE_BUFFER_SOF_EN
    if (in_sof) begin
      col_eff   = '0;
      row_eff   = '0;
      state_eff = FILL;
    end
`endif
  end

  assign col_last = (col_eff == COL_W'(IMAGE_WIDTH - 1));
  assign row_last = (row_eff == ROW_W'(IMAGE_HEIGHT - 1));
  assign load     = accept & (state_eff == STREAM);

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    pix_d   = pix_q;
    valid_d = valid_q;

    if (accept) begin
      state_d = state_eff;
      if (col_last) begin
        col_d = '0;
        row_d = row_last ? '0 : row_eff + ROW_W'(1);
      end else begin
        col_d = col_eff + COL_W'(1);
        row_d = row_eff;
      end
      if ((state_eff == FILL) && col_last && (row_eff == ROW_W'(BLOCK_HEIGHT - 2))) begin
        state_d = STREAM;
      end else if ((state_eff == STREAM) && col_last && row_last) begin
        state_d = FILL;
      end
    end

    // Oldest stored line lands in slice 0, the live pixel in the top slice.
    if (load) begin
      for (int unsigned k = 0; k < LINES; k++) begin
        pix_d[k*DATA_WIDTH +: DATA_WIDTH] = line_q[k][col_eff];
      end
      pix_d[LINES*DATA_WIDTH +: DATA_WIDTH] = in_pixel;
      valid_d = 1'b1;
    end else if (consume) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= FILL;
      col_q   <= '0;
      row_q   <= '0;
      pix_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      pix_q   <= pix_d;
      valid_q <= valid_d;
    end
  end

  // Line memories carry no reset; each column shifts up one line per accept.
  always_ff @(posedge clk) begin
    if (accept) begin
      for (int unsigned k = 0; k + 1 < LINES; k++) begin
        line_q[k][col_eff] <= line_q[k+1][col_eff];
      end
      line_q[LINES-1][col_eff] <= in_pixel;
    end
  end

endmodule

// File: tb/tb_line_buffer.sv
// Bench for line_buffer on a 4x4 frame, 3-row columns; SOF scenario when LINE_BUFFER_SOF_EN.
module tb_line_buffer;

  localparam int unsigned DW    = 8;
  localparam int unsigned BH    = 3;
  localparam int unsigned IW    = 4;
  localparam int unsigned IH    = 4;
  localparam int unsigned OUT_W = DW * BH;

  logic             clk = 1'b0;
  logic             rst;
  logic [DW-1:0]    in_pixel;
  logic             in_valid;
  logic             in_ready;
  logic [OUT_W-1:0] out_pixels;
  logic [BH-1:0]    out_valid;
  logic [BH-1:0]    out_ready;
`ifdef LINE_BUFFER_SOF_EN
  logic             in_sof;
`endif

  int n_total = 0;
  int n_bad   = 0;

  line_buffer #(
    .DATA_WIDTH  (DW),
    .BLOCK_HEIGHT(BH),
    .IMAGE_WIDTH (IW),
    .IMAGE_HEIGHT(IH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_pixel  (in_pixel),
    .in_valid  (in_valid),
`ifdef LINE_BUFFER_SOF_EN
    .in_sof    (in_sof),
`endif
    .in_ready  (in_ready),
    .out_pixels(out_pixels),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
    end
  endtask

  // Reference model: frame image plus a queue of columns owed downstream.
  logic [DW-1:0]    img [IH][IW];
  logic [OUT_W-1:0] sb_q [$];
  logic [OUT_W-1:0] exp_col;
  int               m_row, m_col, r, c;
  bit               exp_load, exp_clear, acc, cons;
  logic             ir_exp;

  always @(negedge clk) begin
    #4;
    if (!rst) begin
      sb_q.delete();
      m_row = 0;
      m_col = 0;
      exp_load  = 0;
      exp_clear = 0;
      check("rst_ov", out_valid, 3'b000);
    end else begin
      if (exp_load)  check("lat_ov", out_valid, 3'b111);
      if (exp_clear) check("clr_ov", out_valid, 3'b000);
      check("ov_eq", out_valid, {3{out_valid[0]}});
      ir_exp = ~out_valid[0] | (&out_ready);
      check("ir_fn", in_ready, ir_exp);
      cons = out_valid[0] && (&out_ready);
      acc  = in_valid && in_ready;
      exp_load  = 0;
      exp_clear = 0;
      if (cons) begin
        if (sb_q.size() == 0) check("sb_under", out_valid, 3'b000);
        else begin
          exp_col = sb_q.pop_front();
          check("col_data", out_pixels, exp_col);
        end
      end
      if (acc) begin
        r = m_row;
        c = m_col;
`ifdef LINE_BUFFER_SOF_EN
        if (in_sof) begin
          r = 0;
          c = 0;
        end
`endif
        img[r][c] = in_pixel;
        if (r >= int'(BH) - 1) begin
          exp_col[(BH-1)*DW +: DW] = in_pixel;
          for (int k = 0; k < int'(BH) - 1; k++) exp_col[k*DW +: DW] = img[r-(int'(BH)-1)+k][c];
          sb_q.push_back(exp_col);
          exp_load = 1;
        end
        c++;
        if (c == int'(IW)) begin
          c = 0;
          r = (r + 1) % int'(IH);
        end
        m_row = r;
        m_col = c;
      end
      if (cons && !exp_load) exp_clear = 1;
    end
  end

  // Offer one pixel from a negedge; returns at the negedge after it is accepted.
  task automatic send(input logic [DW-1:0] pix);
    int n = 0;
    in_pixel = pix;
    in_valid = 1'b1;
    #4;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      #4;
      n++;
    end
    if (!in_ready) check("send_timeout", in_ready, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic send_fill_nooutput(input string tag);
    for (int i = 0; i < 8; i++) begin
      send(DW'(i));
      check(tag, out_valid, 3'b000);
      check({tag, "_ir"}, in_ready, 1'b1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    in_valid = 1'b0;
    in_pixel = '0;
    out_ready = 3'b111;
`ifdef LINE_BUFFER_SOF_EN
    in_sof = 1'b0;
`endif
    repeat (3) @(negedge clk);
    check("reset_ov", out_valid, 3'b000);
    check("reset_pix", out_pixels, 24'h0);
    check("reset_ir", in_ready, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    check("post_reset_ir", in_ready, 1'b1);

    send_fill_nooutput("fill_ov");

    send(8'd8);
    check("first_ov", out_valid, 3'b111);
    check("first_pix", out_pixels, 24'h080400);
    send(8'd9);
    check("col9", out_pixels, 24'h090501);
    send(8'd10);
    check("col10", out_pixels, 24'h0A0602);
    send(8'd11);
    check("col11", out_pixels, 24'h0B0703);

    send(8'd12);
    check("col12", out_pixels, 24'h0C0804);
    out_ready = 3'b101;
    in_pixel = 8'd13;
    in_valid = 1'b1;
    repeat (5) begin
      @(negedge clk);
      check("bp_ir", in_ready, 1'b0);
      check("bp_ov", out_valid, 3'b111);
      check("bp_pix", out_pixels, 24'h0C0804);
    end
    out_ready = 3'b111;
    send(8'd13);
    check("col13", out_pixels, 24'h0D0905);
    send(8'd14);
    check("col14", out_pixels, 24'h0E0A06);
    send(8'd15);
    check("col15", out_pixels, 24'h0F0B07);

    send_fill_nooutput("wrap_ov");
    send(8'd8);
    check("wrap_ov9", out_valid, 3'b111);
    check("wrap_pix9", out_pixels, 24'h080400);

    out_ready = 3'b000;
    #2;
    rst = 1'b0;
    #1;
    check("mid_rst_ov", out_valid, 3'b000);
    check("mid_rst_pix", out_pixels, 24'h0);
    check("mid_rst_ir", in_ready, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    out_ready = 3'b111;
    check("rel_ir", in_ready, 1'b1);
    send_fill_nooutput("rst_fill_ov");
    send(8'd8);
    check("rst_col_pix", out_pixels, 24'h080400);

`ifdef LINE_BUFFER_SOF_EN
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 5; i++) send(DW'(100 + i));
    in_sof = 1'b1;
    send(8'd0);
    in_sof = 1'b0;
    check("sof_ov0", out_valid, 3'b000);
    for (int i = 1; i < 8; i++) begin
      send(DW'(i));
      check("sof_ov", out_valid, 3'b000);
    end
    send(8'd8);
    check("sof_first_ov", out_valid, 3'b111);
    check("sof_first_pix", out_pixels, 24'h080400);
`endif

    for (int i = 0; i < 800; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_pixel  = DW'($urandom);
      out_ready = ($urandom_range(0, 3) == 0) ? BH'($urandom) : 3'b111;
`ifdef LINE_BUFFER_SOF_EN
      in_sof = ($urandom_range(0, 63) == 0);
`endif
      @(negedge clk);
    end
    in_valid  = 1'b0;
    out_ready = 3'b111;
`ifdef LINE_BUFFER_SOF_EN
    in_sof = 1'b0;
`endif
    repeat (4) @(negedge clk);
    check("sb_drain", sb_q.size(), 0);
    check("drain_ov", out_valid, 3'b000);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/line_buffer.md
LINE_BUFFER -- requirements
Module: line_buffer

Interface
REQ-001 The module SHALL have parameter DATA_WIDTH, default 8, giving bits per pixel.
REQ-002 The module SHALL have parameter BLOCK_HEIGHT, default 3, giving the rows per output column; it must match the downstream kernel.
REQ-003 The module SHALL have parameter IMAGE_WIDTH, default 640, giving pixels per line.
REQ-004 The module SHALL have parameter IMAGE_HEIGHT, default 480, giving lines per frame.
REQ-005 Port clk SHALL be an input, 1 bit, the single clock; all logic is rising-edge.
REQ-006 Port rst SHALL be an input, 1 bit, an asynchronous active-low reset.
REQ-007 Port in_pixel SHALL be an input, DATA_WIDTH bits, carrying the raster-order pixel stream.
REQ-008 Port in_valid SHALL be an input, 1 bit, qualifying in_pixel.
REQ-009 Port in_ready SHALL be an output, 1 bit, indicating the pixel can be accepted.
REQ-010 Port out_pixels SHALL be an output, DATA_WIDTH*BLOCK_HEIGHT bits; slice i is row i, slice 0 is the oldest line, slice BLOCK_HEIGHT-1 is the current line.
REQ-011 Port out_valid SHALL be an output, BLOCK_HEIGHT bits, with one bit per row slice.
REQ-012 Port out_ready SHALL be an input, BLOCK_HEIGHT bits, with one bit per downstream row shift register.

Function
REQ-013 Accept SHALL occur when in_valid and in_ready are both 1 on a clock edge.
REQ-014 Internal storage SHALL be BLOCK_HEIGHT-1 line memories of IMAGE_WIDTH entries each, addressed by col.
- On accept at column c: read all lines at c, then shift line[k] <- line[k+1] at c, then write in_pixel into line[BLOCK_HEIGHT-2] at c.
REQ-015 Counter col SHALL advance 0..IMAGE_WIDTH-1 on each accept and wrap to 0.
REQ-016 Counter row SHALL increment when col wraps and wrap to 0 after IMAGE_HEIGHT-1.
REQ-017 The FSM SHALL have two states, FILL and STREAM, behaving as follows:
- FILL: accepts produce no output.
- FILL -> STREAM: on the accept at row=BLOCK_HEIGHT-2, col=IMAGE_WIDTH-1.
- STREAM -> FILL: on the accept at row=IMAGE_HEIGHT-1, col=IMAGE_WIDTH-1, which is the frame wrap.
REQ-018 In STREAM, an accept SHALL load the output register with {in_pixel, line[BLOCK_HEIGHT-2][c], ..., line[0][c]} (MSB to LSB), so slice 0 is the oldest line.
REQ-019 In STREAM, an accept SHALL set all out_valid bits to 1 on the following edge, giving a latency of 1 cycle.
REQ-020 All out_valid bits SHALL always be equal.
REQ-021 The output column SHALL be consumed only on an edge where out_valid=1 and &out_ready=1.
- A partial out_ready SHALL consume nothing.
REQ-022 in_ready SHALL be the combinational function ~out_valid[0] | &out_ready.
- in_ready SHALL not depend on in_valid.
REQ-023 Consume and new load on the same edge SHALL leave out_valid at 1 with the new data, giving full throughput.
REQ-024 Consume with no load SHALL clear out_valid.
REQ-025 While out_valid=1 and out_ready is not all 1s, out_pixels SHALL hold stable.
REQ-026 The frame wrap SHALL clear no line-memory contents; the next frame's FILL overwrites them before any use.

Reset
REQ-027 When rst=0, the following SHALL be cleared immediately and asynchronously:
- out_valid=0, out_pixels=0, col=0, row=0, state=FILL.
REQ-028 Line memories SHALL NOT be reset.
REQ-029 Reset asserted mid-frame SHALL discard any pending output column; after reset the next accepted pixel is treated as frame pixel (0,0).
REQ-030 in_ready SHALL read 1 during reset and immediately after it.

Configuration
REQ-031 With LINE_BUFFER_SOF_EN defined, the module SHALL add a 1-bit input in_sof, and an accepted pixel with in_sof=1 is treated as col=0, row=0, state FILL, overriding the counters.
REQ-032 Without LINE_BUFFER_SOF_EN, the in_sof port SHALL be absent and frame position SHALL come from the counters only.

Verification (IMAGE_WIDTH=4, IMAGE_HEIGHT=4, BLOCK_HEIGHT=3, DATA_WIDTH=8, pixel value = 4*row+col)
REQ-033 Bench SHALL cover fill: stream 8 pixels with out_ready=3'b111 -> out_valid stays 0 and in_ready stays 1.
REQ-034 Bench SHALL cover the first column: accept pixel 8 -> next cycle out_valid=3'b111 and out_pixels={8'd8,8'd4,8'd0}; pixels 9..11 back-to-back give {9,5,1},{10,6,2},{11,7,3} on consecutive cycles.
REQ-035 Bench SHALL cover backpressure: hold out_ready=3'b101 for 5 cycles while a column is valid -> in_ready=0, and out_pixels and out_valid are unchanged; restore 3'b111 -> streaming resumes with no pixel lost or duplicated.
REQ-036 Bench SHALL cover the frame wrap: after 16 accepted pixels, the next 8 pixels give no out_valid, and the 9th gives {8,4,0}.
REQ-037 Bench SHALL cover reset mid-operation: assert rst=0 while out_valid=1 -> out_valid=0 immediately; after release, 8 pixels give no output.
REQ-038 Bench SHALL cover SOF (LINE_BUFFER_SOF_EN only): assert in_sof on the 6th pixel of a frame -> that pixel is (0,0) and the first output appears 8 accepts later.
